serial_sub: RTL and testbench



---
 rtl/serial_sub_pkg.sv | 14 +
 rtl/serial_sub_fs_bit.sv | 16 +
 rtl/serial_sub.sv | 134 +++++++++++++
 tb/tb_serial_sub.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

    // Operation phases: wait for operands, shift one bit per cycle, hold result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 8;

endpackage : serial_sub_pkg

// File: rtl/serial_sub_fs_bit.sv
// One-bit full-subtractor cell: d = x - y - bi, bo = borrow out.
module fs_bit (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    // Difference bit is the three-way parity of the inputs.
    assign d  = x ^ y ^ bi;

    // Borrow when y exceeds x, or when x equals y and a borrow comes in.
    assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule : fs_bit

// File: rtl/serial_sub.sv
// Bit-serial subtractor: captures a, b and bin, then resolves the difference
// one bit per clock (LSB first) through a single full-subtractor cell with a
// registered borrow. The result is held until the consumer takes it.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // Counter only has to reach WIDTH-1, and it stops there instead of wrapping.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_s;
    logic [WIDTH-1:0]   sa_r;
    logic [WIDTH-1:0]   sb_r;
    logic [WIDTH-1:0]   diff_r;
    logic               br_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               d_s;
    logic               bo_s;
    logic               last_s;

    // The single subtract cell always looks at the current LSBs and borrow.
    fs_bit u_cell (
        .x  (sa_r[0]),
        .y  (sb_r[0]),
        .bi (br_r),
        .d  (d_s),
        .bo (bo_s)
    );

    // This SHIFT cycle processes the MSB, so the result is complete after it.
    assign last_s = (cnt_r == CNT_LAST);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and borrow/counter update; all held in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_r   <= '0;
            sb_r   <= '0;
            diff_r <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        sa_r   <= a;
                        sb_r   <= b;
                        br_r   <= bin;
                        diff_r <= '0;
                        cnt_r  <= '0;
                    end
                end
                SHIFT: begin
                    sa_r   <= {1'b0, sa_r[WIDTH-1:1]};
                    sb_r   <= {1'b0, sb_r[WIDTH-1:1]};
                    diff_r <= {d_s, diff_r[WIDTH-1:1]};
                    br_r   <= bo_s;
                    if (!last_s) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    sa_r   <= sa_r;
                    sb_r   <= sb_r;
                    diff_r <= diff_r;
                    br_r   <= br_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    // Handshake flags come straight from the state register; data from flops.
    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign diff       = diff_r;
    assign borrow_out = br_r;

endmodule : serial_sub

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed WIDTH=8 vectors, then an
// exhaustive WIDTH=4 sweep and a random WIDTH=16 sweep against a reference.
module tb_serial_sub;

    logic clk;
    logic rst_n;

    int n_tests;
    int n_fail;

    // WIDTH = 8 instance
    logic       iv8, ir8, ov8, ordy8, bin8, bo8;
    logic [7:0] a8, b8, d8;
    // WIDTH = 4 instance
    logic       iv4, ir4, ov4, ordy4, bin4, bo4;
    logic [3:0] a4, b4, d4;
    // WIDTH = 16 instance
    logic        iv16, ir16, ov16, ordy16, bin16, bo16;
    logic [15:0] a16, b16, d16;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .bin(bin8), .out_valid(ov8), .out_ready(ordy8),
        .diff(d8), .borrow_out(bo8)
    );

    serial_sub #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .bin(bin4), .out_valid(ov4), .out_ready(ordy4),
        .diff(d4), .borrow_out(bo4)
    );

    serial_sub #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .bin(bin16), .out_valid(ov16), .out_ready(ordy16),
        .diff(d16), .borrow_out(bo16)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; checks latency and {borrow,diff}. Transfers only if ordy8=1.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [8:0] exp);
        int n;
        check_eq({tag, "_in_ready"}, 32'(ir8), 32'd1);
        a8 = av; b8 = bv; bin8 = bi; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        n = 0;
        while (!ov8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd8);
        check_eq({tag, "_result"}, 32'({bo8, d8}), 32'(exp));
        if (ordy8) begin
            @(posedge clk);
            @(negedge clk);
            check_eq({tag, "_ov_after"}, 32'(ov8), 32'd0);
            check_eq({tag, "_ir_after"}, 32'(ir8), 32'd1);
        end
    endtask

    task automatic op4(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        logic [4:0] e;
        int n;
        e = {1'b0, av} - {1'b0, bv} - {4'd0, bi};
        a4 = av; b4 = bv; bin4 = bi; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        n = 0;
        while (!ov4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("w4_sweep", 32'({bo4, d4}), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic bi);
        logic [16:0] e;
        int n;
        e = {1'b0, av} - {1'b0, bv} - {16'd0, bi};
        a16 = av; b16 = bv; bin16 = bi; iv16 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv16 = 1'b0;
        n = 0;
        while (!ov16 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("w16_sweep", 32'({bo16, d16}), 32'(e));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] hold_d;
        logic       hold_bo;
        logic       seen_ov;
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        iv8 = 1'b0;  ordy8 = 1'b1;  a8 = 8'd0;   b8 = 8'd0;   bin8 = 1'b0;
        iv4 = 1'b0;  ordy4 = 1'b1;  a4 = 4'd0;   b4 = 4'd0;   bin4 = 1'b0;
        iv16 = 1'b0; ordy16 = 1'b1; a16 = 16'd0; b16 = 16'd0; bin16 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset state
        check_eq("rst_in_ready", 32'(ir8), 32'd1);
        check_eq("rst_out_valid", 32'(ov8), 32'd0);
        check_eq("rst_diff", 32'(d8), 32'd0);
        check_eq("rst_borrow", 32'(bo8), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors, hand-computed {borrow_out, diff}
        op8("sub_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h01E);
        op8("sub_00_01", 8'h00, 8'h01, 1'b0, 9'h1FF);
        op8("sub_80_80_b", 8'h80, 8'h80, 1'b1, 9'h1FF);
        op8("equal", 8'hA5, 8'hA5, 1'b0, 9'h000);
        op8("min_max_b", 8'h00, 8'hFF, 1'b1, 9'h100);
        op8("max_min", 8'hFF, 8'h00, 1'b1, 9'h0FE);

        // Backpressure: result held for 5 cycles, new operands ignored
        ordy8 = 1'b0;
        op8("bp", 8'h33, 8'h11, 1'b0, 9'h022);
        hold_d  = d8;
        hold_bo = bo8;
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_diff_stable", 32'(d8), 32'(hold_d));
            check_eq("bp_borrow_stable", 32'(bo8), 32'(hold_bo));
            check_eq("bp_in_ready_low", 32'(ir8), 32'd0);
            check_eq("bp_out_valid_high", 32'(ov8), 32'd1);
        end
        iv8 = 1'b0;
        ordy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_ov_after", 32'(ov8), 32'd0);
        check_eq("bp_ir_after", 32'(ir8), 32'd1);
        @(negedge clk);
        check_eq("bp_idle_stays", 32'(ir8), 32'd1);

        // Reset during SHIFT cycle 3
        a8 = 8'h5A; b8 = 8'h3C; bin8 = 1'b0; iv8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("mid_in_shift", 32'(ir8), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_ov", 32'(ov8), 32'd0);
        check_eq("mid_rst_ir", 32'(ir8), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ov8) seen_ov = 1'b1;
        end
        check_eq("mid_no_result", 32'(seen_ov), 32'd0);
        op8("after_rst", 8'h10, 8'h01, 1'b0, 9'h00F);

        // WIDTH = 4 exhaustive sweep
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    op4(4'(x), 4'(y), 1'(c));
                end
            end
        end

        // WIDTH = 16 random sweep plus corner cases
        op16(16'h0000, 16'hFFFF, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        op16(16'h8000, 16'h0001, 1'b0);
        for (int i = 0; i < 500; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_serial_sub
